// File: rtl/verificador_gato.sv
// Tic-tac-toe result checker: decodes the 3x3 board into per-player win/loss/tie flags
// and line codes, captured into one output register stage on each verifica_status strobe.
module verificador_gato (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       verifica_status,
    input  logic [1:0] reg_c1,
    input  logic [1:0] reg_c2,
    input  logic [1:0] reg_c3,
    input  logic [1:0] reg_c4,
    input  logic [1:0] reg_c5,
    input  logic [1:0] reg_c6,
    input  logic [1:0] reg_c7,
    input  logic [1:0] reg_c8,
    input  logic [1:0] reg_c9,
    output logic       p1_win,
    output logic       p1_loss,
    output logic       p1_tie,
    output logic       p2_win,
    output logic       p2_loss,
    output logic       p2_tie,
    output logic [1:0] linea_horizontal,
    output logic [1:0] linea_vertical,
    output logic [1:0] linea_cruzada
);

    localparam logic [1:0] CodeP1 = 2'b01;
    localparam logic [1:0] CodeP2 = 2'b11;

    logic [8:0][1:0] board;
    assign board = {reg_c9, reg_c8, reg_c7, reg_c6, reg_c5, reg_c4, reg_c3, reg_c2, reg_c1};

    // Line bits: [2:0] rows top..bottom, [5:3] columns left..right, [6] c1-c5-c9, [7] c3-c5-c7
    function automatic logic [7:0] lines_of(input logic [8:0][1:0] b, input logic [1:0] code);
        logic [8:0] m;
        for (int i = 0; i < 9; i++) begin
            m[i] = (b[i] == code);
        end
        return {m[2] & m[4] & m[6], m[0] & m[4] & m[8],
                m[2] & m[5] & m[8], m[1] & m[4] & m[7], m[0] & m[3] & m[6],
                m[6] & m[7] & m[8], m[3] & m[4] & m[5], m[0] & m[1] & m[2]};
    endfunction

    logic [7:0] lines_p1, lines_p2, lines_win;
    logic       any_p1, any_p2, board_full, tie;
    logic [1:0] horiz_d, vert_d, cruz_d;

    always_comb begin
        lines_p1 = lines_of(board, CodeP1);
        lines_p2 = lines_of(board, CodeP2);
        any_p1   = |lines_p1;
        any_p2   = |lines_p2;
        // Bit 0 is set only for the two player codes, so invalid 10 never counts as filled
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            board_full = board_full & board[i][0];
        end
        tie = ~any_p1 & ~any_p2 & board_full;

        if (any_p1) begin
            lines_win = lines_p1;
        end else if (any_p2) begin
            lines_win = lines_p2;
        end else begin
            lines_win = 8'b0;
        end

        if (lines_win[0]) begin
            horiz_d = 2'b01;
        end else if (lines_win[1]) begin
            horiz_d = 2'b10;
        end else if (lines_win[2]) begin
            horiz_d = 2'b11;
        end else begin
            horiz_d = 2'b00;
        end

        if (lines_win[3]) begin
            vert_d = 2'b01;
        end else if (lines_win[4]) begin
            vert_d = 2'b10;
        end else if (lines_win[5]) begin
            vert_d = 2'b11;
        end else begin
            vert_d = 2'b00;
        end

        if (lines_win[6]) begin
            cruz_d = 2'b01;
        end else if (lines_win[7]) begin
            cruz_d = 2'b10;
        end else begin
            cruz_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_win           <= 1'b0;
            p1_loss          <= 1'b0;
            p1_tie           <= 1'b0;
            p2_win           <= 1'b0;
            p2_loss          <= 1'b0;
            p2_tie           <= 1'b0;
            linea_horizontal <= 2'b00;
            linea_vertical   <= 2'b00;
            linea_cruzada    <= 2'b00;
        end else if (verifica_status) begin
            p1_win           <= any_p1;
            p1_loss          <= ~any_p1 & any_p2;
            p1_tie           <= tie;
            p2_win           <= ~any_p1 & any_p2;
            p2_loss          <= any_p1;
            p2_tie           <= tie;
            linea_horizontal <= horiz_d;
            linea_vertical   <= vert_d;
            linea_cruzada    <= cruz_d;
        end
    end

endmodule

// File: tb/tb_verificador_gato.sv
// Scoreboard bench for verificador_gato: stimulus queues expected outputs per clock edge,
// a negedge monitor pops and compares them.
module tb_verificador_gato;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       verifica_status = 1'b0;
    logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic       p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie;
    logic [1:0] linea_horizontal, linea_vertical, linea_cruzada;

    always #5 clk = ~clk;

    verificador_gato dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .verifica_status  (verifica_status),
        .reg_c1           (c1),
        .reg_c2           (c2),
        .reg_c3           (c3),
        .reg_c4           (c4),
        .reg_c5           (c5),
        .reg_c6           (c6),
        .reg_c7           (c7),
        .reg_c8           (c8),
        .reg_c9           (c9),
        .p1_win           (p1_win),
        .p1_loss          (p1_loss),
        .p1_tie           (p1_tie),
        .p2_win           (p2_win),
        .p2_loss          (p2_loss),
        .p2_tie           (p2_tie),
        .linea_horizontal (linea_horizontal),
        .linea_vertical   (linea_vertical),
        .linea_cruzada    (linea_cruzada)
    );

    typedef struct {
        string       name;
        logic [11:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic stim_done = 1'b0;

    // Expected vector layout: {p1w,p1l,p1t, p2w,p2l,p2t, horiz, vert, cruz}
    localparam logic [11:0] Zero  = 12'b000_000_00_00_00;
    localparam logic [11:0] Tie   = 12'b001_001_00_00_00;

    // board = {c1,c2,c3, c4,c5,c6, c7,c8,c9}
    task automatic step(input string name, input logic [17:0] b, input logic vs,
                        input logic rn, input logic [11:0] exp);
        {c1, c2, c3, c4, c5, c6, c7, c8, c9} = b;
        verifica_status = vs;
        rst_n = rn;
        @(posedge clk);
        #1;
        q.push_back('{name, exp});
    endtask

    initial begin : monitor
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie,
                       linea_horizontal, linea_vertical, linea_cruzada};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %b required %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin : stimulus
        logic [17:0] p1_top;
        logic [17:0] p2_diag;
        logic [17:0] tie_board;
        p1_top    = {2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        p2_diag   = {2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11};
        tie_board = {2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};

        step("reset0", p1_top, 1'b1, 1'b0, Zero);
        step("reset1", p1_top, 1'b1, 1'b0, Zero);
        step("post_reset_idle", p1_top, 1'b0, 1'b1, Zero);
        step("p2_diag_idle", p2_diag, 1'b0, 1'b1, Zero);
        step("p2_diag", p2_diag, 1'b1, 1'b1, 12'b010_100_00_00_01);
        step("hold0", 18'b0, 1'b0, 1'b1, 12'b010_100_00_00_01);
        step("hold1", 18'b0, 1'b0, 1'b1, 12'b010_100_00_00_01);
        step("empty_eval", 18'b0, 1'b1, 1'b1, Zero);
        step("p1_row_col",
             {2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00},
             1'b1, 1'b1, 12'b100_010_01_01_00);
        step("tie", tie_board, 1'b1, 1'b1, Tie);
        step("tie_c9_invalid", {tie_board[17:2], 2'b10}, 1'b1, 1'b1, Zero);
        step("conflict",
             {2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11},
             1'b1, 1'b1, 12'b100_010_01_00_00);
        step("p2_bottom_right",
             {2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11},
             1'b1, 1'b1, 12'b010_100_11_11_00);
        step("p1_both_diags",
             {2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01},
             1'b1, 1'b1, 12'b100_010_00_00_01);
        step("p1_anti_diag",
             {2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00},
             1'b1, 1'b1, 12'b100_010_00_00_10);
        step("p1_two_rows",
             {2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01},
             1'b1, 1'b1, 12'b100_010_10_00_00);
        step("p1_mid_col",
             {2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00},
             1'b1, 1'b1, 12'b100_010_00_10_00);
        step("invalid_row", {2'b10, 2'b10, 2'b10, 12'b0}, 1'b1, 1'b1, Zero);
        step("p2_win_again", p2_diag, 1'b1, 1'b1, 12'b010_100_00_00_01);
        step("reset_over_strobe", p1_top, 1'b1, 1'b0, Zero);
        step("final_eval", p1_top, 1'b1, 1'b1, 12'b100_010_01_00_00);
        stim_done = 1'b1;

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
